// File: rtl/mult_result_serializer_pkg.sv
// Shared constants and state encoding for the multiplier result path.
package mult_result_serializer_pkg;

   localparam int unsigned RESULT_W = 128;
   localparam int unsigned WORD_W   = 32;
   localparam int unsigned N_WORDS  = RESULT_W / WORD_W;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACK  = 2'd1,
      SEND = 2'd2
   } state_e;

endpackage

// File: rtl/mult_result_serializer_word_mux_reg.sv
// Registered N_WORDS:1 word selector driven by an internal word index.
module mult_result_serializer_word_mux_reg #(
   parameter int unsigned WORD_W  = 32,
   parameter int unsigned N_WORDS = 4,
   parameter int unsigned IDX_W   = 2
) (
   input  logic                        i_clk,
   input  logic                        i_rst_n,
   input  logic [N_WORDS*WORD_W-1:0]   i_bus,
   input  logic                        i_clear,
   input  logic                        i_load,
   input  logic                        i_advance,
   output logic [WORD_W-1:0]           o_data,
   output logic [IDX_W-1:0]            o_idx
);

   logic [WORD_W-1:0] w_words [N_WORDS];
   logic [IDX_W-1:0]  w_sel_idx;
   logic [IDX_W-1:0]  r_idx;
   logic [WORD_W-1:0] r_data;

   for (genvar gi = 0; gi < N_WORDS; gi++) begin : g_words
      assign w_words[gi] = i_bus[gi*WORD_W +: WORD_W];
   end

   // Load restarts at word 0; advance steps to the next word.
   always_comb begin
      w_sel_idx = r_idx + 1'b1;
      if (i_load) begin
         w_sel_idx = '0;
      end
   end

   // Index and output word register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_idx  <= '0;
         r_data <= '0;
      end else if (i_clear) begin
         r_idx  <= '0;
         r_data <= '0;
      end else if (i_load || i_advance) begin
         r_idx  <= w_sel_idx;
         r_data <= w_words[w_sel_idx];
      end
   end

   assign o_data = r_data;
   assign o_idx  = r_idx;

endmodule

// File: rtl/mult_result_serializer.sv
// Captures a multiplier result on Done/Acknowledge and streams it out LSW first.
module mult_result_serializer #(
   parameter int unsigned RESULT_W = mult_result_serializer_pkg::RESULT_W,
   parameter int unsigned WORD_W   = mult_result_serializer_pkg::WORD_W,
   parameter int unsigned CNT_W    = 16
) (
   input  logic                Clock,
   input  logic                Reset,
   input  logic                iDone,
   input  logic [RESULT_W-1:0] iResult,
   output logic                oAck,
   output logic [WORD_W-1:0]   oData,
   output logic                oValid,
   input  logic                iReady,
   output logic                oLast,
   output logic                oBusy,
   output logic [CNT_W-1:0]    oCount
);

   import mult_result_serializer_pkg::*;

   localparam int unsigned N_WORDS = RESULT_W / WORD_W;
   localparam int unsigned IDX_W   = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORDS - 1);

   if ((RESULT_W % WORD_W) != 0) begin : g_bad_width
      $error("RESULT_W must be an integer multiple of WORD_W");
   end

   state_e              r_state, w_state_d;
   logic                r_ack, w_ack_d;
   logic                r_valid, w_valid_d;
   logic                r_last, w_last_d;
   logic [CNT_W-1:0]    r_count, w_count_d;
   logic [RESULT_W-1:0] r_capture;
   logic                w_capture_en;
   logic                w_clear;
   logic                w_load;
   logic                w_advance;
   logic [IDX_W-1:0]    w_idx;
   logic [WORD_W-1:0]   w_data;

   // Next-state and registered-output decode.
   always_comb begin
      w_state_d    = r_state;
      w_ack_d      = r_ack;
      w_valid_d    = r_valid;
      w_last_d     = r_last;
      w_count_d    = r_count;
      w_capture_en = 1'b0;
      w_clear      = 1'b0;
      w_load       = 1'b0;
      w_advance    = 1'b0;
      case (r_state)
         IDLE: begin
            w_ack_d   = 1'b0;
            w_valid_d = 1'b0;
            w_last_d  = 1'b0;
            if (iDone) begin
               w_state_d    = ACK;
               w_ack_d      = 1'b1;
               w_capture_en = 1'b1;
               w_clear      = 1'b1;
            end
         end
         ACK: begin
            // Multiplier releases Done once it has seen the acknowledge.
            if (!iDone) begin
               w_state_d = SEND;
               w_ack_d   = 1'b0;
               w_valid_d = 1'b1;
               w_last_d  = (N_WORDS == 1);
               w_load    = 1'b1;
            end
         end
         SEND: begin
            if (r_valid && iReady) begin
               if (w_idx == LAST_IDX) begin
                  w_state_d = IDLE;
                  w_valid_d = 1'b0;
                  w_last_d  = 1'b0;
                  w_count_d = r_count + 1'b1;
               end else begin
                  w_advance = 1'b1;
                  w_last_d  = ((w_idx + 1'b1) == LAST_IDX);
               end
            end
         end
         default: begin
            w_state_d = IDLE;
            w_ack_d   = 1'b0;
            w_valid_d = 1'b0;
            w_last_d  = 1'b0;
            w_clear   = 1'b1;
         end
      endcase
   end

   // State, handshake outputs and completed-result counter.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         r_state <= IDLE;
         r_ack   <= 1'b0;
         r_valid <= 1'b0;
         r_last  <= 1'b0;
         r_count <= '0;
      end else begin
         r_state <= w_state_d;
         r_ack   <= w_ack_d;
         r_valid <= w_valid_d;
         r_last  <= w_last_d;
         r_count <= w_count_d;
      end
   end

   // Result capture, only on the IDLE edge that sees Done.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         r_capture <= '0;
      end else if (w_capture_en) begin
         r_capture <= iResult;
      end
   end

   mult_result_serializer_word_mux_reg #(
      .WORD_W  (WORD_W),
      .N_WORDS (N_WORDS),
      .IDX_W   (IDX_W)
   ) u_word_mux_reg (
      .i_clk     (Clock),
      .i_rst_n   (Reset),
      .i_bus     (r_capture),
      .i_clear   (w_clear),
      .i_load    (w_load),
      .i_advance (w_advance),
      .o_data    (w_data),
      .o_idx     (w_idx)
   );

   assign oAck   = r_ack;
   assign oData  = w_data;
   assign oValid = r_valid;
   assign oLast  = r_last;
   assign oBusy  = (r_state != IDLE);
   assign oCount = r_count;

endmodule

// File: tb/tb_mult_result_serializer.sv
// Scoreboard bench: driver pushes expected words, negedge monitor pops and compares.
module tb_mult_result_serializer;

   typedef struct packed {
      logic [31:0] word;
      logic        last;
   } exp_t;

   logic          Clock;
   logic          Reset;
   logic          iDone;
   logic [127:0]  iResult;
   logic          iReady;
   logic          oAck, oValid, oLast, oBusy;
   logic [31:0]   oData;
   logic [15:0]   oCount;
   logic          b_ack, b_valid, b_last, b_busy;
   logic [31:0]   b_data;
   logic [1:0]    b_count;

   int   n_checks;
   int   n_errors;
   exp_t exp_q[$];
   int   exp_count;
   int   mon_word_idx;
   bit   streaming;
   int   stall_seen;
   bit   stall_arm;
   int   stall_cnt;
   bit   rand_ready;

   mult_result_serializer dut_a (
      .Clock   (Clock),
      .Reset   (Reset),
      .iDone   (iDone),
      .iResult (iResult),
      .oAck    (oAck),
      .oData   (oData),
      .oValid  (oValid),
      .iReady  (iReady),
      .oLast   (oLast),
      .oBusy   (oBusy),
      .oCount  (oCount)
   );

   mult_result_serializer #(.CNT_W(2)) dut_b (
      .Clock   (Clock),
      .Reset   (Reset),
      .iDone   (iDone),
      .iResult (iResult),
      .oAck    (b_ack),
      .oData   (b_data),
      .oValid  (b_valid),
      .iReady  (iReady),
      .oLast   (b_last),
      .oBusy   (b_busy),
      .oCount  (b_count)
   );

   initial begin
      Clock = 1'b0;
      forever #5 Clock = ~Clock;
   end

   task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s: got %0h want %0h", name, got, want);
      end
   endtask

   task automatic fail(input string name);
      n_checks++;
      n_errors++;
      $display("FAIL %s: got timeout want event", name);
   endtask

   function automatic logic [127:0] rnd128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   task automatic clear_model();
      exp_q.delete();
      exp_count    = 0;
      mon_word_idx = 0;
      streaming    = 1'b0;
   endtask

   // Multiplier-side handshake: raise Done, wait for Ack, hold, release.
   task automatic send(input logic [127:0] r, input int hold);
      bit got;
      @(posedge Clock); #1;
      iDone   = 1'b1;
      iResult = r;
      got     = 1'b0;
      for (int t = 0; t < 400; t++) begin
         @(posedge Clock); #1;
         if (oAck) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) begin
         fail("ack_timeout");
         iDone = 1'b0;
         return;
      end
      check("ack_after_prev_done", 128'(exp_q.size()), 128'(0));
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back('{word: r[i*32 +: 32], last: (i == 3)});
      end
      iResult = rnd128();
      for (int h = 0; h < hold; h++) begin
         check("ack_hold", 128'(oAck), 128'(1));
         check("no_valid_in_ack", 128'(oValid), 128'(0));
         @(posedge Clock); #1;
      end
      iDone = 1'b0;
      @(posedge Clock); #1;
      check("valid_after_done_drop", 128'(oValid), 128'(1));
      check("ack_drop", 128'(oAck), 128'(0));
   endtask

   task automatic drain();
      bit done;
      done = 1'b0;
      for (int t = 0; t < 600; t++) begin
         if (exp_q.size() == 0 && !streaming) begin
            done = 1'b1;
            break;
         end
         @(posedge Clock); #1;
      end
      if (!done) fail("drain_timeout");
      check("busy_after", 128'(oBusy), 128'(0));
      check("valid_after", 128'(oValid), 128'(0));
      check("b_busy_after", 128'(b_busy), 128'(0));
   endtask

   task automatic do_reset();
      @(posedge Clock); #1;
      iDone = 1'b0;
      Reset = 1'b0;
      clear_model();
      repeat (2) @(posedge Clock);
      #1 Reset = 1'b1;
   endtask

   // Ready generator: always, random, or a scripted 5-cycle stall on word 2.
   initial begin
      stall_cnt = 0;
      forever begin
         @(posedge Clock); #1;
         if (stall_arm && oValid && mon_word_idx == 1) begin
            stall_cnt = 5;
            stall_arm = 1'b0;
         end
         if (stall_cnt > 0) begin
            iReady = 1'b0;
            stall_cnt--;
         end else begin
            iReady = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         end
      end
   end

   // Monitor: compare presented words and counters against the scoreboard.
   always @(negedge Clock) begin
      if (Reset) begin
         check("count", 128'(oCount), 128'(exp_count % 65536));
         check("count_w2", 128'(b_count), 128'(exp_count % 4));
         if (oValid) begin
            streaming = 1'b1;
            if (exp_q.size() == 0) begin
               check("unexpected_word", 128'(oData), 128'(0));
               n_errors++;
            end else begin
               check("word", 128'(oData), 128'(exp_q[0].word));
               check("last", 128'(oLast), 128'(exp_q[0].last));
               if (b_valid) check("b_word", 128'(b_data), 128'(exp_q[0].word));
               if (b_valid) check("b_last", 128'(b_last), 128'(exp_q[0].last));
               if (!iReady) stall_seen++;
               if (iReady) begin
                  if (exp_q[0].last) begin
                     exp_count++;
                     streaming    = 1'b0;
                     mon_word_idx = 0;
                  end else begin
                     mon_word_idx++;
                  end
                  void'(exp_q.pop_front());
               end
            end
         end else if (streaming) begin
            check("valid_drop", 128'(oValid), 128'(1));
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish want finish");
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors + 1);
      $fatal(1);
   end

   initial begin
      bit got;
      n_checks   = 0;
      n_errors   = 0;
      stall_seen = 0;
      stall_arm  = 1'b0;
      rand_ready = 1'b0;
      Reset      = 1'b0;
      iDone      = 1'b0;
      iResult    = '0;
      iReady     = 1'b1;
      clear_model();

      // Reset state
      repeat (8) @(posedge Clock);
      #1;
      check("rst_ack", 128'(oAck), 128'(0));
      check("rst_valid", 128'(oValid), 128'(0));
      check("rst_last", 128'(oLast), 128'(0));
      check("rst_busy", 128'(oBusy), 128'(0));
      check("rst_data", 128'(oData), 128'(0));
      check("rst_count", 128'(oCount), 128'(0));
      Reset = 1'b1;

      // 1: basic transfer
      send(128'h00000004_00000003_00000002_00000001, 1);
      drain();
      check("t1_count", 128'(oCount), 128'(1));

      // 2: backpressure on word 2
      do_reset();
      stall_seen = 0;
      stall_arm  = 1'b1;
      send(128'h00000004_00000003_00000002_00000001, 1);
      drain();
      check("t2_stall_cycles", 128'(stall_seen), 128'(5));
      check("t2_count", 128'(oCount), 128'(1));

      // 3: late Done drop
      do_reset();
      send(rnd128(), 6);
      drain();
      check("t3_count", 128'(oCount), 128'(1));

      // 4: back-to-back, second Done during first SEND
      do_reset();
      send(128'h1, 1);
      send(128'hFFFFFFFF_00000000_DEADBEEF_00000002, 1);
      drain();
      check("t4_count", 128'(oCount), 128'(2));

      // 5: reset mid-SEND after word 2 accepted
      do_reset();
      send(rnd128(), 0);
      got = 1'b0;
      for (int t = 0; t < 50; t++) begin
         if (mon_word_idx == 2) begin
            got = 1'b1;
            break;
         end
         @(posedge Clock); #1;
      end
      if (!got) fail("t5_word2_timeout");
      #1 Reset = 1'b0;
      #1;
      check("t5_valid", 128'(oValid), 128'(0));
      check("t5_ack", 128'(oAck), 128'(0));
      check("t5_count", 128'(oCount), 128'(0));
      check("t5_busy", 128'(oBusy), 128'(0));
      check("t5_b_valid", 128'(b_valid), 128'(0));
      check("t5_b_ack", 128'(b_ack), 128'(0));
      clear_model();
      repeat (3) @(posedge Clock);
      #1 Reset = 1'b1;
      send(rnd128(), 1);
      drain();
      check("t5_count_after", 128'(oCount), 128'(1));

      // 6: counter wrap on the 2-bit instance
      do_reset();
      for (int i = 0; i < 5; i++) send(rnd128(), int'($urandom_range(0, 3)));
      drain();
      check("t6_count", 128'(oCount), 128'(5));
      check("t6_count_w2", 128'(b_count), 128'(1));

      // 7: random results with random ready and random Done hold
      do_reset();
      rand_ready = 1'b1;
      for (int i = 0; i < 20; i++) send(rnd128(), int'($urandom_range(0, 3)));
      drain();
      rand_ready = 1'b0;
      check("t7_count", 128'(oCount), 128'(20));
      check("t7_count_w2", 128'(b_count), 128'(0));

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/mult_result_serializer.md
Name: mult_result_serializer

Overview:
- Downstream stage of the 4x4 multiplier (Four_Multiplicador).
- Consumes the 128-bit result using the multiplier's Done/Acknowledge handshake, then streams it out as four 32-bit words, least-significant word first, on a valid/ready interface.
- Holds back the multiplier's acknowledge until its own buffer is free. This applies backpressure to the multiplier.
- Keeps a count of completed results.

Parameters:
- RESULT_W, 128, width of the multiplier result bus.
- WORD_W, 32, width of each output word. RESULT_W must be an integer multiple of WORD_W.
- N_WORDS, RESULT_W/WORD_W (4), number of words per result. Derived; not overridable.
- CNT_W, 16, width of the completed-result counter.

Ports:
- Clock  in  1  system clock; all flops on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- iDone  in  1  multiplier oDone; result is valid while high.
- iResult  in  RESULT_W  multiplier oResult.
- oAck  out  1  to the multiplier's iAcknoledged.
- oData  out  WORD_W  current output word.
- oValid  out  1  oData is valid.
- iReady  in  1  consumer accepts the word when oValid && iReady at a rising edge.
- oLast  out  1  high with oValid on the final word (index N_WORDS-1).
- oBusy  out  1  high in any state other than IDLE.
- oCount  out  CNT_W  number of results fully streamed; wraps modulo 2^CNT_W.

Behaviour:
- Reset low (asynchronous): state=IDLE, oAck=0, oValid=0, oLast=0, oBusy=0, oData=0, oCount=0, word index=0, capture register=0.
- Reset is asserted asynchronously and released synchronously to Clock.
- Reset mid-operation discards the captured result, drops oAck and oValid immediately, and does not increment oCount.

State machine:
- IDLE → ACK: when iDone=1 at a rising edge.
  - Latch iResult into the capture register on that edge.
  - Assert oAck=1 from the next cycle.
  - Set index=0.
- ACK: hold oAck=1 while iDone=1.
  - ACK → SEND: when iDone=0. oAck drops to 0 and oValid rises to 1 on the same edge.
- SEND: oData = capture[index*WORD_W +: WORD_W], registered.
  - On oValid && iReady: index increments and oData updates next cycle.
  - On the last word (index N_WORDS-1) accepted: oValid=0, oLast=0, oCount+1, state → IDLE.
  - While iReady=0: oData, oValid and oLast stay stable indefinitely.
- Outputs are registered. oBusy = (state != IDLE).

Timing and boundary conditions:
- Minimum latency: iDone sampled high → first oValid is 2 cycles if iDone falls the cycle after oAck rises. Four words stream back-to-back with iReady held high.
- Capture happens only in IDLE. iDone activity in ACK is handled as above. In SEND, iDone is not acknowledged; the multiplier stays in Done until this block returns to IDLE.
- iDone already high in IDLE on the cycle after the last word is accepted: capture on the next edge. Gap of one IDLE cycle minimum.
- iResult changing while oAck=1 has no effect; only the IDLE-edge capture is used.
- oCount wraps from 2^CNT_W-1 to 0 with no flag.
- No unknown states: the default branch goes to IDLE with outputs cleared.

Decomposition:
- Shared package/header (e.g. mult_pkg): RESULT_W, WORD_W, N_WORDS and the state encodings IDLE=2'd0, ACK=2'd1, SEND=2'd2.
  - Also used by the multiplier and the upstream operand stage.
- One natural sub-module: word_mux_reg, a registered N_WORDS:1 word selector indexed by a counter with load/advance enables.
- The FSM and counter stay in the top module.

Test Plan:
1. Basic transfer.
   - Stimulus: reset low 8 cycles then high; iResult=128'h00000004_00000003_00000002_00000001; iDone high 1 cycle before the edge; drop iDone one cycle after oAck=1; iReady=1.
   - Required: oAck pulses high; words 1,2,3,4 appear on consecutive cycles; oLast is high only with 4; oCount=1; oBusy=0 afterwards.
2. Backpressure.
   - Stimulus: same as scenario 1, but iReady=0 for 5 cycles during word 2.
   - Required: oData=32'h00000002 and oValid=1 held stable for all 5 cycles; sequence completes afterwards; oCount=1.
3. Late Done drop.
   - Stimulus: iDone stays high 6 cycles after oAck rises.
   - Required: oAck stays high for those 6 cycles; no oValid until the cycle after iDone falls.
4. Back-to-back results with the multiplier testbench handshake.
   - Stimulus: two results, 128'h1 and 128'hFFFFFFFF_00000000_DEADBEEF_00000002; second iDone arrives during SEND of the first.
   - Required: second oAck only after the first oLast handshake; words 00000002, DEADBEEF, 00000000, FFFFFFFF; oCount=2.
5. Reset mid-SEND.
   - Stimulus: assert Reset low asynchronously after word 2 is accepted.
   - Required: oValid=0 and oAck=0 immediately; oCount=0; after release, the next iDone captures a fresh result starting at word index 0.
6. Counter wrap.
   - Stimulus: with CNT_W=2, stream 5 results.
   - Required: oCount sequence 1,2,3,0,1.
